// File: rtl/rv32i_types.sv
// Shared RV32I types: MEM-stage FSM state, load/store funct3 encodings and access-width decode.
package rv32i_types;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD} acc_width_t;

   // Undefined funct3 encodings fall back to a full word access.
   function automatic acc_width_t access_width(input logic is_store, input logic [2:0] f3);
      acc_width_t w;
      w = ACC_WORD;
      if (is_store) begin
         if (f3 == SB)      w = ACC_BYTE;
         else if (f3 == SH) w = ACC_HALF;
      end else begin
         if (f3 == LB || f3 == LBU)      w = ACC_BYTE;
         else if (f3 == LH || f3 == LHU) w = ACC_HALF;
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational load extract/extend, store lane replication, byte mask and misalignment check.
module mem_align
   import rv32i_types::*;
(
   input  logic [2:0]      i_ld_funct3,
   input  logic [1:0]      i_ld_off,
   input  logic [XLEN-1:0] i_rdata,
   input  logic [2:0]      i_funct3,
   input  logic            i_is_store,
   input  logic [1:0]      i_off,
   input  logic [XLEN-1:0] i_rs2,
   output logic [XLEN-1:0] o_load_data,
   output logic [XLEN-1:0] o_wdata,
   output logic [3:0]      o_be,
   output logic            o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   acc_width_t  w_width;

   assign w_byte  = i_rdata[{i_ld_off, 3'b000} +: 8];
   assign w_half  = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
   assign w_width = access_width(i_is_store, i_funct3);

   always_comb begin
      o_load_data = i_rdata;
      case (i_ld_funct3)
         LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
         LBU:     o_load_data = {24'h0, w_byte};
         LH:      o_load_data = {{16{w_half[15]}}, w_half};
         LHU:     o_load_data = {16'h0, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

   // Byte enables are only meaningful for stores; the top substitutes 4'hF for reads.
   always_comb begin
      o_wdata      = i_rs2;
      o_be         = 4'b1111;
      o_misaligned = 1'b0;
      case (w_width)
         ACC_BYTE: begin
            o_wdata = {4{i_rs2[7:0]}};
            o_be    = 4'b0001 << i_off;
         end
         ACC_HALF: begin
            o_wdata      = {2{i_rs2[15:0]}};
            o_be         = 4'b0011 << i_off;
            o_misaligned = i_off[0];
         end
         default: begin
            o_misaligned = (i_off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit: issues aligned cache requests and stalls until the response.
module mem_stage_access_unit
   import rv32i_types::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] rs2_out,
   input  logic              ext_stall,
   output logic [ADDR_W-1:0] dmem_address,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_byte_enable,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_resp,
   output logic              mem_stall,
   output logic [DATA_W-1:0] load_data,
   output logic              misaligned
);

   mem_state_t        r_state;
   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_be;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [DATA_W-1:0] r_load_data;

   logic              w_pending;
   logic              w_mis;
   logic [DATA_W-1:0] w_fmt;
   logic [DATA_W-1:0] w_wdata;
   logic [3:0]        w_be;

   assign w_pending = valid_in & (mem_read | mem_write);

   mem_align u_align (
      .i_ld_funct3  (r_funct3),
      .i_ld_off     (r_off),
      .i_rdata      (dmem_rdata),
      .i_funct3     (funct3),
      .i_is_store   (mem_write),
      .i_off        (alu_out[1:0]),
      .i_rs2        (rs2_out),
      .o_load_data  (w_fmt),
      .o_wdata      (w_wdata),
      .o_be         (w_be),
      .o_misaligned (w_mis)
   );

   // Request FSM; a write wins when mem_read and mem_write are both set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= 4'h0;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
         r_load_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pending && !w_mis) begin
                  r_state  <= REQ;
                  r_addr   <= {alu_out[ADDR_W-1:2], 2'b00};
                  r_read   <= ~mem_write;
                  r_write  <= mem_write;
                  r_wdata  <= mem_write ? w_wdata : '0;
                  r_be     <= mem_write ? w_be : 4'hF;
                  r_funct3 <= funct3;
                  r_off    <= alu_out[1:0];
               end
            end
            REQ: begin
               if (dmem_resp) begin
                  r_read      <= 1'b0;
                  r_write     <= 1'b0;
                  r_load_data <= w_fmt;
                  r_state     <= ext_stall ? DONE : IDLE;
               end
            end
            DONE: begin
               if (!ext_stall) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Stall, misalignment flag and the response-cycle bypass of load_data.
   always_comb begin
      mem_stall  = 1'b0;
      misaligned = 1'b0;
      load_data  = r_load_data;
      if (rst) begin
         load_data = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pending) begin
                  if (w_mis) begin
                     misaligned = 1'b1;
                     load_data  = '0;
                  end else begin
                     mem_stall = 1'b1;
                  end
               end
            end
            REQ: begin
               if (!dmem_resp)      mem_stall = 1'b1;
               else if (!ext_stall) load_data = w_fmt;
            end
            default: ;
         endcase
      end
   end

   assign dmem_address     = r_addr;
   assign dmem_read        = r_read;
   assign dmem_write       = r_write;
   assign dmem_wdata       = r_wdata;
   assign dmem_byte_enable = r_be;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Randomized bench for mem_stage_access_unit against an arithmetic model of the access rules.
module tb_mem_stage_access_unit;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] alu_out;
   logic [31:0] rs2_out;
   logic        ext_stall;
   logic [31:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_byte_enable;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        mem_stall;
   logic [31:0] load_data;
   logic        misaligned;

   int n_checks;
   int n_errors;
   int exp_reqs;
   int seen_reqs;
   logic prev_req;

   mem_stage_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .valid_in         (valid_in),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .funct3           (funct3),
      .alu_out          (alu_out),
      .rs2_out          (rs2_out),
      .ext_stall        (ext_stall),
      .dmem_address     (dmem_address),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_wdata       (dmem_wdata),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .mem_stall        (mem_stall),
      .load_data        (load_data),
      .misaligned       (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts distinct cache transactions (rising edges of the request).
   always @(negedge clk) begin
      if ((dmem_read || dmem_write) && !prev_req) seen_reqs <= seen_reqs + 1;
      prev_req <= dmem_read || dmem_write;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Access size in bytes.
   function automatic int ref_width(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
      int off;
      int v;
      off = int'(addr[1:0]);
      case (ref_width(1'b0, f3))
         1: begin
            v = int'((rdata >> (8 * off)) & 32'hFF);
            if (f3 == 3'd0 && v >= 128) v = v - 256;
            return 32'(v);
         end
         2: begin
            v = int'((rdata >> (16 * (off / 2))) & 32'hFFFF);
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            return 32'(v);
         end
         default: return rdata;
      endcase
   endfunction

   task automatic bubble();
      valid_in  = 1'b0;
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      alu_out   = $urandom;
      dmem_resp = 1'b0;
      @(negedge clk);
      check("bub_stall", 32'(mem_stall), 32'd0);
      check("bub_mis", 32'(misaligned), 32'd0);
      check("bub_req", 32'(dmem_read | dmem_write), 32'd0);
      @(posedge clk); #1;
   endtask

   // One MEM-stage instruction: issue, lat-cycle response, ext_n cycles of external hold.
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] rdata, input int lat, input int ext_n);
      int          w;
      int          off;
      logic        mis;
      logic [31:0] exp_ld;
      logic [31:0] exp_wd;
      logic [3:0]  exp_be;
      w      = ref_width(wr, f3);
      off    = int'(addr[1:0]);
      mis    = (off % w) != 0;
      exp_ld = ref_load(f3, addr, rdata);
      exp_wd = (w == 1) ? 32'(rs2[7:0]) * 32'h01010101 :
               (w == 2) ? 32'(rs2[15:0]) * 32'h00010001 : rs2;
      exp_be = !wr ? 4'hF : (w == 4) ? 4'hF : (w == 1) ? 4'(1 << off) : 4'(3 << off);

      valid_in   = 1'b1;
      mem_read   = rd;
      mem_write  = wr;
      funct3     = f3;
      alu_out    = addr;
      rs2_out    = rs2;
      ext_stall  = 1'b0;
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
      @(negedge clk);
      check("idle_req", 32'(dmem_read | dmem_write), 32'd0);
      check("iss_mis", 32'(misaligned), 32'(mis));
      check("iss_stall", 32'(mem_stall), 32'(!mis));
      if (mis) begin
         check("mis_ld", load_data, 32'd0);
         @(posedge clk); #1;
         return;
      end
      exp_reqs++;
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         if (c == lat) begin
            dmem_resp  = 1'b1;
            dmem_rdata = rdata;
            ext_stall  = (ext_n > 0);
         end else begin
            dmem_rdata = $urandom;
         end
         @(negedge clk);
         check("req_rd", 32'(dmem_read), 32'(!wr));
         check("req_wr", 32'(dmem_write), 32'(wr));
         check("req_addr", dmem_address, {addr[31:2], 2'b00});
         check("req_be", 32'(dmem_byte_enable), 32'(exp_be));
         if (wr) check("req_wdata", dmem_wdata, exp_wd);
         check("req_stall", 32'(mem_stall), (c == lat) ? 32'd0 : 32'd1);
         if (c == lat && ext_n == 0 && !wr) check("ld_comb", load_data, exp_ld);
      end
      for (int d = 0; d < ext_n; d++) begin
         @(posedge clk); #1;
         dmem_resp  = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
         ext_stall  = (d < ext_n - 1);
         @(negedge clk);
         check("done_req", 32'(dmem_read | dmem_write), 32'd0);
         check("done_stall", 32'(mem_stall), 32'd0);
         if (!wr) check("done_ld", load_data, exp_ld);
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      ext_stall = 1'b0;
   endtask

   initial begin
      logic rd;
      logic wr;
      int   sel;
      n_checks   = 0;
      n_errors   = 0;
      exp_reqs   = 0;
      seen_reqs  = 0;
      prev_req   = 1'b0;
      rst        = 1'b1;
      valid_in   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'd0;
      alu_out    = 32'd0;
      rs2_out    = 32'd0;
      ext_stall  = 1'b0;
      dmem_rdata = 32'd0;
      dmem_resp  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_rd", 32'(dmem_read), 32'd0);
      check("rst_wr", 32'(dmem_write), 32'd0);
      check("rst_be", 32'(dmem_byte_enable), 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_ld", load_data, 32'd0);
      check("rst_mis", 32'(misaligned), 32'd0);
      @(posedge clk); #1;

      // Directed scenarios
      do_access(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 3, 0);
      do_access(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
      do_access(1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
      do_access(1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 32'h80017FFF, 1, 0);
      do_access(1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'h80017FFF, 1, 0);
      do_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 2, 0);
      do_access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h12345678, 1, 0);
      do_access(1'b0, 1'b1, 3'd1, 32'h103, 32'h5555AAAA, 32'h0, 1, 0);
      do_access(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 1, 3);
      do_access(1'b1, 1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0, 1, 0);

      // Reset while the request is outstanding; a late response must be ignored.
      valid_in  = 1'b1;
      mem_read  = 1'b1;
      mem_write = 1'b0;
      funct3    = 3'd2;
      alu_out   = 32'h500;
      @(negedge clk);
      check("rr_iss_stall", 32'(mem_stall), 32'd1);
      exp_reqs++;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      valid_in = 1'b0;
      @(negedge clk);
      check("rr_rd", 32'(dmem_read), 32'd0);
      check("rr_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h87654321;
      @(negedge clk);
      check("late_stall", 32'(mem_stall), 32'd0);
      check("late_ld", load_data, 32'd0);
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      @(negedge clk);
      check("late_ld_after", load_data, 32'd0);
      check("late_req", 32'(dmem_read | dmem_write), 32'd0);
      @(posedge clk); #1;

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            bubble();
         end else begin
            sel = int'($urandom_range(0, 3));
            rd  = (sel != 1);
            wr  = (sel == 1 || sel == 2);
            do_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      int'($urandom_range(1, 4)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         end
      end
      bubble();
      @(negedge clk);
      check("req_count", 32'(seen_reqs), 32'(exp_reqs));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- MEM-stage data-memory access unit for the 5-stage RV32I pipeline.
- Consumes the MEM-stage fields of the control word (mem_read, mem_write, funct3) together with the EX/MEM ALU result and rs2 data.
- Issues aligned word requests to the data cache and holds the pipeline until the cache responds.
- Returns sign/zero-extended load data to the MEM/WB register and flags misaligned accesses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, present only for readability.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  EX/MEM register holds a live instruction.
- mem_read  in  1  control word mem_read.
- mem_write  in  1  control word mem_write.
- funct3  in  3  control word funct3 (load/store width and sign).
- alu_out  in  32  effective byte address.
- rs2_out  in  32  store source data.
- ext_stall  in  1  stall requested by another stage (e.g. I-cache miss).
- dmem_address  out  32  word-aligned address: {alu_out[31:2],2'b00}.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_byte_enable  out  4  store byte mask.
- dmem_rdata  in  32  read data, valid with dmem_resp.
- dmem_resp  in  1  single-cycle completion pulse.
- mem_stall  out  1  freeze PC and all pipeline registers.
- load_data  out  32  formatted load result to MEM/WB.
- misaligned  out  1  access suppressed because of misalignment.

Behaviour:
- State type: {IDLE, REQ, DONE}. Reset value is IDLE.
- Reset values of outputs: dmem_read=0, dmem_write=0, dmem_byte_enable=0, dmem_wdata=0, mem_stall=0, load_data=0, misaligned=0.
- An access is pending when valid_in & (mem_read | mem_write).
- If mem_read and mem_write are both set, perform the write only.
- Misalignment rule:
  - lh/lhu/sh are misaligned when alu_out[0]=1.
  - lw/sw are misaligned when alu_out[1:0]!=0.
  - Byte accesses are never misaligned.
  - A misaligned access issues no request; misaligned=1 combinationally that cycle; load_data=0; no stall.
- IDLE with an aligned pending access:
  - mem_stall=1 combinationally.
  - Register address, wdata, byte_enable, funct3, alu_out[1:0] and read/write.
  - Next state is REQ.
- REQ:
  - Drive dmem_read/dmem_write and the registered fields, stable, until dmem_resp.
  - mem_stall=1 in every cycle in which dmem_resp=0.
- REQ with dmem_resp=1:
  - Drop the request in the next cycle.
  - Capture formatted rdata into load_data.
  - If ext_stall=0: mem_stall=0 this cycle, load_data is driven combinationally from the formatter, and the next state is IDLE.
  - If ext_stall=1: go to DONE.
- Minimum latency: a 1-cycle cache response gives a 2-cycle MEM occupancy (cycle T issue, T+1 response). Back-to-back accesses therefore need no idle gap.
- DONE:
  - mem_stall=0. load_data holds the registered value. No request is issued.
  - Stay in DONE while ext_stall=1; go to IDLE when ext_stall=0.
  - This prevents re-issuing the same instruction while another stage holds the pipeline.
- Load formatting, with byte offset o=alu_out[1:0]:
  - lb: sign-extend rdata[8o+7:8o].
  - lbu: zero-extend rdata[8o+7:8o].
  - lh: sign-extend rdata[16o[1]+15:16o[1]].
  - lhu: zero-extend the same halfword.
  - lw: pass rdata unchanged.
  - Undefined funct3 values are treated as lw.
- Store formatting:
  - sb: wdata={4{rs2[7:0]}}, byte_enable=4'b0001<<o.
  - sh: wdata={2{rs2[15:0]}}, byte_enable=4'b0011<<o.
  - sw: wdata=rs2, byte_enable=4'b1111.
  - For reads, dmem_byte_enable=4'b1111.
- dmem_resp arriving in IDLE or DONE is ignored.
- rst asserted in REQ drops the request in the next cycle and returns to IDLE. The cache is reset by the same rst.
- valid_in=0 (bubble): no request, no stall.

Decomposition:
- Add the mem_state_t enum {IDLE, REQ, DONE} to rv32i_types.
- Reuse load_funct3_t and store_funct3_t from rv32i_types for width decode.
- Sub-module: mem_align, purely combinational. It holds the load extractor/extender, the store lane replication, the byte-mask generator and the misalignment check.
- The top level holds the FSM and the request registers.

Test Plan:
1. sw, alu_out=0x100, rs2=0xDEADBEEF, resp at T+3 -> dmem_write=1 with be=1111 and addr=0x100 from T+1 to T+3; mem_stall=1 for T..T+2 and 0 at T+3; 4 MEM cycles total.
2. lb, alu_out=0x203, rdata=0x80FF1234, 1-cycle resp -> load_data=0xFFFFFF80; lbu at the same address -> 0x00000080.
3. lh/lhu, alu_out=0x202, rdata=0x8001_7FFF -> lh=0xFFFF8001, lhu=0x00008001. sh with rs2=0x0000ABCD at 0x202 -> wdata=0xABCDABCD, be=1100.
4. lw at 0x101 -> no dmem_read, misaligned=1, mem_stall=0. sh at 0x103 -> misaligned=1, no write.
5. lw with resp while ext_stall=1 for 3 cycles -> FSM in DONE, load_data held, exactly one dmem_read transaction, no re-issue.
6. rst asserted in REQ -> next cycle dmem_read=0, mem_stall=0, state IDLE. A late dmem_resp is ignored.
